// File: rtl/pipe_ctrl.sv
// Front-end sequencing controller: fetch PC steering, branch redirect,
// single-bubble load-use stall, halt latch and stall/flush counters.
module pipe_ctrl #(
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 'h01000000,
  parameter int                CWIDTH   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic              id_valid_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              ex_valid_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              ex_is_load_i,
  input  logic              ex_br_taken_i,
  input  logic [AWIDTH-1:0] ex_br_target_i,
  input  logic              halt_i,
  output logic              pc_en_o,
  output logic [AWIDTH-1:0] next_pc_o,
  output logic              if_id_en_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              halted_o,
  output logic [CWIDTH-1:0] stall_cnt_o,
  output logic [CWIDTH-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_LD_STALL,
    S_HALTED
  } state_t;

  localparam logic [AWIDTH-1:0] C_FOUR = AWIDTH'(4);
  localparam logic [AWIDTH-1:0] C_MASK = ~AWIDTH'(3);

  state_t            r_state;
  state_t            w_next;
  logic [CWIDTH-1:0] r_stall_cnt;
  logic [CWIDTH-1:0] r_flush_cnt;
  logic              w_hazard;
  logic              w_redirect;
  logic              w_stall_inc;
  logic              w_flush_inc;
  logic [AWIDTH-1:0] w_redir_pc;
  logic [AWIDTH-1:0] w_boot_pc;

  assign w_hazard = ex_valid_i && ex_is_load_i &&
                    (ex_rd_i != 5'd0) && id_valid_i &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  assign w_redirect = ex_valid_i && ex_br_taken_i;

  // Fetch adds 4 to whatever it loads, so pre-subtract it here.
  assign w_redir_pc = (ex_br_target_i & C_MASK) - C_FOUR;
  assign w_boot_pc  = BASEADDR - C_FOUR;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    pc_en_o       = 1'b0;
    next_pc_o     = pc_i;
    if_id_en_o    = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    halted_o      = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    if (rst) begin
      w_next        = S_BOOT;
      next_pc_o     = w_boot_pc;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          w_next        = S_RUN;
          next_pc_o     = w_boot_pc;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end
        S_RUN, S_LD_STALL: begin
          if (halt_i) begin
            w_next        = S_HALTED;
            id_ex_flush_o = 1'b1;
          end else if (w_redirect) begin
            w_next        = S_RUN;
            pc_en_o       = 1'b1;
            next_pc_o     = w_redir_pc;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            w_flush_inc   = 1'b1;
          end else if (r_state == S_RUN && w_hazard) begin
            // One bubble only: LD_STALL never re-checks the hazard.
            w_next        = S_LD_STALL;
            id_ex_flush_o = 1'b1;
            w_stall_inc   = 1'b1;
          end else begin
            w_next     = S_RUN;
            pc_en_o    = 1'b1;
            if_id_en_o = 1'b1;
          end
        end
        S_HALTED: begin
          id_ex_flush_o = 1'b1;
          halted_o      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a 2-bit-counter copy shares the
// stimulus to exercise counter saturation.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_uses_rs1_i;
  logic        id_uses_rs2_i;
  logic        ex_valid_i;
  logic [4:0]  ex_rd_i;
  logic        ex_is_load_i;
  logic        ex_br_taken_i;
  logic [31:0] ex_br_target_i;
  logic        halt_i;

  logic        pc_en_o;
  logic [31:0] next_pc_o;
  logic        if_id_en_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        halted_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  logic        s_pc_en;
  logic [31:0] s_next_pc;
  logic        s_if_id_en;
  logic        s_if_id_flush;
  logic        s_id_ex_flush;
  logic        s_halted;
  logic [1:0]  s_stall_cnt;
  logic [1:0]  s_flush_cnt;

  int errors = 0;
  int checks = 0;

  pipe_ctrl u_dut (
    .clk(clk), .rst(rst), .pc_i(pc_i),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_uses_rs1_i(id_uses_rs1_i),
    .id_uses_rs2_i(id_uses_rs2_i), .ex_valid_i(ex_valid_i),
    .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
    .ex_br_taken_i(ex_br_taken_i),
    .ex_br_target_i(ex_br_target_i), .halt_i(halt_i),
    .pc_en_o(pc_en_o), .next_pc_o(next_pc_o),
    .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_flush_o(id_ex_flush_o), .halted_o(halted_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_ctrl #(.CWIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .pc_i(pc_i),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_uses_rs1_i(id_uses_rs1_i),
    .id_uses_rs2_i(id_uses_rs2_i), .ex_valid_i(ex_valid_i),
    .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
    .ex_br_taken_i(ex_br_taken_i),
    .ex_br_target_i(ex_br_target_i), .halt_i(halt_i),
    .pc_en_o(s_pc_en), .next_pc_o(s_next_pc),
    .if_id_en_o(s_if_id_en), .if_id_flush_o(s_if_id_flush),
    .id_ex_flush_o(s_id_ex_flush), .halted_o(s_halted),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    id_uses_rs1_i = 0; id_uses_rs2_i = 0;
    ex_valid_i = 0; ex_rd_i = 0; ex_is_load_i = 0;
    ex_br_taken_i = 0; ex_br_target_i = 0; halt_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hazard();
    ex_valid_i = 1; ex_is_load_i = 1; ex_rd_i = 5;
    id_valid_i = 1; id_rs1_i = 5; id_rs2_i = 1;
    id_uses_rs1_i = 1; id_uses_rs2_i = 1;
  endtask

  task automatic test_reset();
    rst = 1; pc_i = 32'h01000000; clear_in();
    #1;
    checks++;
    if (pc_en_o !== 1'b0 || if_id_en_o !== 1'b0 ||
        if_id_flush_o !== 1'b1 || id_ex_flush_o !== 1'b1 ||
        halted_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl: got en=%b ifen=%b fl=%b%b h=%b want 0 0 11 0",
               pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, halted_o);
    end
    checks++;
    if (next_pc_o !== 32'h00FFFFFC) begin
      errors++;
      $display("FAIL rst_npc: got %h want 00fffffc", next_pc_o);
    end
    step(); step();
    rst = 0;
    #1;
    checks++;
    if (pc_en_o !== 1'b0 || if_id_flush_o !== 1'b1 ||
        id_ex_flush_o !== 1'b1 || stall_cnt_o !== 0 ||
        flush_cnt_o !== 0) begin
      errors++;
      $display("FAIL boot: got en=%b fl=%b%b sc=%0d fc=%0d want 0 11 0 0",
               pc_en_o, if_id_flush_o, id_ex_flush_o,
               stall_cnt_o, flush_cnt_o);
    end
    step();
    #1;
    checks++;
    if (pc_en_o !== 1'b1 || next_pc_o !== 32'h01000000 ||
        if_id_en_o !== 1'b1 || if_id_flush_o !== 1'b0 ||
        id_ex_flush_o !== 1'b0) begin
      errors++;
      $display("FAIL run_adv: got en=%b npc=%h ifen=%b fl=%b%b want 1 01000000 1 00",
               pc_en_o, next_pc_o, if_id_en_o, if_id_flush_o, id_ex_flush_o);
    end
  endtask

  task automatic test_load_use();
    step();
    set_hazard();
    #1;
    checks++;
    if (pc_en_o !== 1'b0 || if_id_en_o !== 1'b0 ||
        id_ex_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got en=%b ifen=%b idex=%b want 0 0 1",
               pc_en_o, if_id_en_o, id_ex_flush_o);
    end
    step();
    #1;
    checks++;
    if (stall_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL lu_cnt: got %0d want 1", stall_cnt_o);
    end
    checks++;
    if (pc_en_o !== 1'b1 || if_id_en_o !== 1'b1 ||
        id_ex_flush_o !== 1'b0) begin
      errors++;
      $display("FAIL lu_one_bubble: got en=%b ifen=%b idex=%b want 1 1 0",
               pc_en_o, if_id_en_o, id_ex_flush_o);
    end
    step();
    clear_in();
  endtask

  task automatic test_redirect();
    ex_valid_i = 1; ex_br_taken_i = 1;
    ex_br_target_i = 32'h01000040;
    #1;
    checks++;
    if (pc_en_o !== 1'b1 || next_pc_o !== 32'h0100003C ||
        if_id_flush_o !== 1'b1 || id_ex_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL redir: got en=%b npc=%h fl=%b%b want 1 0100003c 11",
               pc_en_o, next_pc_o, if_id_flush_o, id_ex_flush_o);
    end
    step();
    clear_in();
    checks++;
    if (flush_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL redir_cnt: got %0d want 1", flush_cnt_o);
    end
  endtask

  task automatic test_redirect_hazard();
    set_hazard();
    ex_br_taken_i = 1;
    ex_br_target_i = 32'h01000081;
    #1;
    checks++;
    if (pc_en_o !== 1'b1 || next_pc_o !== 32'h0100007C ||
        if_id_flush_o !== 1'b1 || id_ex_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL rh_redir: got en=%b npc=%h fl=%b%b want 1 0100007c 11",
               pc_en_o, next_pc_o, if_id_flush_o, id_ex_flush_o);
    end
    step();
    checks++;
    if (stall_cnt_o !== 32'd1 || flush_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL rh_cnt: got sc=%0d fc=%0d want 1 2",
               stall_cnt_o, flush_cnt_o);
    end
    ex_br_taken_i = 0;
    #1;
    checks++;
    if (pc_en_o !== 1'b0 || id_ex_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL rh_still_run: got en=%b idex=%b want 0 1",
               pc_en_o, id_ex_flush_o);
    end
    step();
    clear_in();
    step();
    checks++;
    if (stall_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL rh_stall2: got %0d want 2", stall_cnt_o);
    end
  endtask

  task automatic test_x0_wrap();
    ex_valid_i = 1; ex_is_load_i = 1; ex_rd_i = 0;
    id_valid_i = 1; id_rs1_i = 0; id_uses_rs1_i = 1;
    #1;
    checks++;
    if (pc_en_o !== 1'b1 || id_ex_flush_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_nostall: got en=%b idex=%b want 1 0",
               pc_en_o, id_ex_flush_o);
    end
    step();
    clear_in();
    checks++;
    if (stall_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL x0_cnt: got %0d want 2", stall_cnt_o);
    end
    ex_valid_i = 1; ex_br_taken_i = 1;
    ex_br_target_i = 32'h00000003;
    #1;
    checks++;
    if (next_pc_o !== 32'hFFFFFFFC || pc_en_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap3: got npc=%h en=%b want fffffffc 1",
               next_pc_o, pc_en_o);
    end
    step();
    ex_br_target_i = 32'h00000004;
    #1;
    checks++;
    if (next_pc_o !== 32'h00000000) begin
      errors++;
      $display("FAIL wrap4: got %h want 00000000", next_pc_o);
    end
    step();
    clear_in();
    checks++;
    if (flush_cnt_o !== 32'd4 || s_flush_cnt !== 2'd3) begin
      errors++;
      $display("FAIL flush_sat: got %0d/%0d want 4/3",
               flush_cnt_o, s_flush_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 2; i++) begin
      set_hazard();
      step();
      clear_in();
      step();
    end
    checks++;
    if (stall_cnt_o !== 32'd4 || s_stall_cnt !== 2'd3) begin
      errors++;
      $display("FAIL stall_sat: got %0d/%0d want 4/3",
               stall_cnt_o, s_stall_cnt);
    end
  endtask

  task automatic test_halt();
    set_hazard();
    halt_i = 1; ex_br_taken_i = 1;
    #1;
    checks++;
    if (pc_en_o !== 1'b0 || if_id_en_o !== 1'b0 ||
        id_ex_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL halt_req: got en=%b ifen=%b idex=%b want 0 0 1",
               pc_en_o, if_id_en_o, id_ex_flush_o);
    end
    step();
    halt_i = 0;
    checks++;
    if (stall_cnt_o !== 32'd4 || flush_cnt_o !== 32'd4) begin
      errors++;
      $display("FAIL halt_cnt: got %0d/%0d want 4/4",
               stall_cnt_o, flush_cnt_o);
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (pc_en_o !== 1'b0 || halted_o !== 1'b1 ||
          id_ex_flush_o !== 1'b1) begin
        errors++;
        $display("FAIL halted_%0d: got en=%b h=%b idex=%b want 0 1 1",
                 i, pc_en_o, halted_o, id_ex_flush_o);
      end
      step();
    end
    clear_in();
    rst = 1;
    #1;
    checks++;
    if (halted_o !== 1'b0 || pc_en_o !== 1'b0) begin
      errors++;
      $display("FAIL halt_rst: got h=%b en=%b want 0 0", halted_o, pc_en_o);
    end
    step();
    rst = 0;
    #1;
    checks++;
    if (stall_cnt_o !== 0 || flush_cnt_o !== 0 || s_stall_cnt !== 0 ||
        pc_en_o !== 1'b0 || id_ex_flush_o !== 1'b1 || halted_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_boot: got sc=%0d fc=%0d ss=%0d en=%b idex=%b h=%b",
               stall_cnt_o, flush_cnt_o, s_stall_cnt,
               pc_en_o, id_ex_flush_o, halted_o);
    end
    step();
    #1;
    checks++;
    if (pc_en_o !== 1'b1 || next_pc_o !== 32'h01000000) begin
      errors++;
      $display("FAIL rerun: got en=%b npc=%h want 1 01000000",
               pc_en_o, next_pc_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_hazard();
    test_x0_wrap();
    test_saturation();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
